// File: rtl/frame_scrambler_pkg.sv
// Shared constants and types for the line-side frame scrambler and its receive-side descrambler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: frame geometry defaults, scrambler seed, polynomial taps (x^16+x^12+x^3+x+1),
// sync state encoding, and a single-step feedback helper.
package frame_scrambler_pkg;

  localparam int          FRAME_BYTES_DEF = 4164;      // 4 rows x 1041 cols
  localparam int          FAS_BYTES_DEF   = 6;         // F6 F6 F6 28 28 28
  localparam logic [15:0] SEED_DEF        = 16'hFFFF;
  localparam int          CNT_W           = 13;

  // Feedback taps on the 16-bit state: s[15]^s[11]^s[2]^s[0].
  localparam logic [15:0] LFSR_TAPS = 16'h8805;

  typedef enum logic [1:0] {
    ST_UNSYNC   = 2'd0,
    ST_BYPASS   = 2'd1,
    ST_SCRAMBLE = 2'd2
  } scr_state_t;

  // New bit shifted into s[0] on one LFSR step.
  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/scr_lfsr_step8.sv
// Combinational 8-step scrambler LFSR: byte key plus state after eight shifts.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides whether to register next_state.
//
// Ports:
//   state_cur  in  16  current LFSR state
//   key        out  8  keystream byte, first generated bit in key[7]
//   state_nxt  out 16  state after eight shifts
module scr_lfsr_step8
  import frame_scrambler_pkg::*;
(
  input  logic [15:0] state_cur,
  output logic [7:0]  key,
  output logic [15:0] state_nxt
);

  logic [15:0] s;

  // Each step emits s[15] as the key bit, then shifts left with the feedback bit in s[0].
  always_comb begin
    s   = state_cur;
    key = '0;
    for (int i = 7; i >= 0; i--) begin
      key[i] = s[15];
      s      = {s[14:0], lfsr_fb(s)};
    end
    state_nxt = s;
  end

endmodule

// File: rtl/frame_scrambler.sv
// Frame-synchronous additive scrambler between frame mapper and line serializer; checks FAS spacing.
// Latency: 1 cycle for every valid byte, input to output.
// Backpressure: none; every valid input byte is accepted and emitted one cycle later.
//
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_frame_data/_valid/_fas            mapped byte stream, FAS marks first FAS byte
//   i_scr_en                            1 = scramble, 0 = pass-through (keystream still advances)
//   o_line_data/_valid/_fas             registered scrambled stream
//   o_locked                            set after a correctly spaced FAS pair
//   o_frame_err                         one-cycle pulse on misplaced or missing FAS
module frame_scrambler
  import frame_scrambler_pkg::*;
#(
  parameter int          FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int          FAS_BYTES   = FAS_BYTES_DEF,
  parameter logic [15:0] SEED        = SEED_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_data_valid,
  input  logic       i_frame_data_fas,
  input  logic       i_scr_en,
  output logic [7:0] o_line_data,
  output logic       o_line_data_valid,
  output logic       o_line_data_fas,
  output logic       o_locked,
  output logic       o_frame_err
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0] BYP_LAST  = CNT_W'(FAS_BYTES - 1);

  scr_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      lfsr, lfsr_nxt, lfsr_adv;
  logic [7:0]       key;
  logic [7:0]       data_nxt;
  logic             locked_nxt;
  logic             err_nxt;

  scr_lfsr_step8 u_lfsr (
    .state_cur (lfsr),
    .key       (key),
    .state_nxt (lfsr_adv)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lfsr_nxt   = lfsr;
    locked_nxt = o_locked;
    err_nxt    = 1'b0;
    data_nxt   = 8'h00;

    if (i_frame_data_valid) begin
      data_nxt = i_frame_data;
      cnt_nxt  = cnt + CNT_ONE;

      if (i_frame_data_fas) begin
        // Any FAS (re)starts the bypass window; spacing is only judged once synced.
        cnt_nxt   = CNT_ONE;
        state_nxt = ST_BYPASS;
        if (state != ST_UNSYNC) begin
          if (cnt == FRAME_END) begin
            locked_nxt = 1'b1;
          end else begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
          end
        end
      end else if (state != ST_UNSYNC && cnt == FRAME_END) begin
        // Expected FAS did not arrive: drop sync, this byte passes through untouched.
        err_nxt    = 1'b1;
        locked_nxt = 1'b0;
        state_nxt  = ST_UNSYNC;
      end else begin
        case (state)
          ST_BYPASS: begin
            // Last FAS byte: seed the keystream for the first payload byte.
            if (cnt == BYP_LAST) begin
              lfsr_nxt  = SEED;
              state_nxt = ST_SCRAMBLE;
            end
          end
          ST_SCRAMBLE: begin
            lfsr_nxt = lfsr_adv;
            if (i_scr_en) begin
              data_nxt = i_frame_data ^ key;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= ST_UNSYNC;
      cnt               <= '0;
      lfsr              <= SEED;
      o_line_data       <= '0;
      o_line_data_valid <= 1'b0;
      o_line_data_fas   <= 1'b0;
      o_locked          <= 1'b0;
      o_frame_err       <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      lfsr              <= lfsr_nxt;
      o_line_data       <= data_nxt;
      o_line_data_valid <= i_frame_data_valid;
      o_line_data_fas   <= i_frame_data_valid & i_frame_data_fas;
      o_locked          <= locked_nxt;
      o_frame_err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_frame_scrambler.sv
// Self-checking bench for frame_scrambler: fixed vector table, hand-written corner sequences,
// and randomized frames compared against a frame-position reference model.
// Latency / backpressure: drives one byte per cycle, expects each result one clock later.
module tb_frame_scrambler;

  localparam int FB   = 4164;
  localparam int FASB = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_vld = 1'b0;
  logic       in_fas = 1'b0;
  logic       scr_en = 1'b0;
  logic [7:0] line_data;
  logic       line_vld;
  logic       line_fas;
  logic       locked;
  logic       frame_err;

  always #5 clk = ~clk;

  frame_scrambler dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_frame_data       (in_data),
    .i_frame_data_valid (in_vld),
    .i_frame_data_fas   (in_fas),
    .i_scr_en           (scr_en),
    .o_line_data        (line_data),
    .o_line_data_valid  (line_vld),
    .o_line_data_fas    (line_fas),
    .o_locked           (locked),
    .o_frame_err        (frame_err)
  );

  int checks = 0;
  int passes = 0;

  // Reference keystream for payload byte positions FASB..FB-1, generated bit-serially from the seed.
  logic [7:0] key_tab [FB];

  // Reference model state: whether a frame is being tracked, and the position within it.
  bit  m_sync;
  int  m_pos;
  bit  m_locked;
  logic [7:0] exp_data;
  bit  exp_vld, exp_fas, exp_err;

  typedef struct {
    logic [7:0] d;
    bit         f;
    logic [7:0] exp_d;
    bit         exp_f;
  } vec_t;
  vec_t tv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic build_keys();
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int n = 0; n < FB; n++) begin
      for (int b = 7; b >= 0; b--) begin
        key_tab[n][b] = s[15];
        fb = s[15] ^ s[11] ^ s[2] ^ s[0];
        s  = {s[14:0], fb};
      end
    end
  endtask

  task automatic model_reset();
    m_sync   = 1'b0;
    m_pos    = 0;
    m_locked = 1'b0;
  endtask

  task automatic model(input logic [7:0] d, input bit v, input bit f, input bit en);
    exp_vld  = v;
    exp_fas  = v & f;
    exp_err  = 1'b0;
    exp_data = 8'h00;
    if (v) begin
      exp_data = d;
      if (f) begin
        if (m_sync) begin
          exp_err  = (m_pos != FB);
          m_locked = !exp_err;
        end
        m_sync = 1'b1;
        m_pos  = 1;
      end else if (m_sync && m_pos == FB) begin
        exp_err  = 1'b1;
        m_locked = 1'b0;
        m_sync   = 1'b0;
      end else begin
        if (m_sync && m_pos >= FASB && en) exp_data = d ^ key_tab[m_pos - FASB];
        m_pos++;
      end
    end
  endtask

  task automatic cyc(input logic [7:0] d, input bit v, input bit f, input bit en);
    @(negedge clk);
    in_data = d;
    in_vld  = v;
    in_fas  = f;
    scr_en  = en;
    model(d, v, f, en);
    @(posedge clk);
    #1;
    check("cycle {data,vld,fas,err,locked}",
          {line_data, line_vld, line_fas, frame_err, locked},
          {exp_data, exp_vld, exp_fas, exp_err, m_locked});
  endtask

  task automatic fas_hdr(input bit en);
    cyc(8'hF6, 1'b1, 1'b1, en);
    cyc(8'hF6, 1'b1, 1'b0, en);
    cyc(8'hF6, 1'b1, 1'b0, en);
    cyc(8'h28, 1'b1, 1'b0, en);
    cyc(8'h28, 1'b1, 1'b0, en);
    cyc(8'h28, 1'b1, 1'b0, en);
  endtask

  // Valid bytes at frame positions first..last; gap_pct gives the chance of an idle cycle before each.
  task automatic run_bytes(input int first, input int last, input int gap_pct, input bit en);
    for (int i = first; i <= last; i++) begin
      if (gap_pct != 0 && $urandom_range(99) < gap_pct)
        cyc(8'($urandom), 1'b0, 1'($urandom), en);
      cyc(8'($urandom), 1'b1, 1'b0, en);
    end
  endtask

  initial begin
    build_keys();
    model_reset();

    tv[0] = '{8'hF6, 1'b1, 8'hF6, 1'b1};
    tv[1] = '{8'hF6, 1'b0, 8'hF6, 1'b0};
    tv[2] = '{8'hF6, 1'b0, 8'hF6, 1'b0};
    tv[3] = '{8'h28, 1'b0, 8'h28, 1'b0};
    tv[4] = '{8'h28, 1'b0, 8'h28, 1'b0};
    tv[5] = '{8'h28, 1'b0, 8'h28, 1'b0};
    tv[6] = '{8'h00, 1'b0, 8'hFF, 1'b0};
    tv[7] = '{8'h00, 1'b0, 8'hFF, 1'b0};

    // Reset state
    #12;
    check("reset outputs", {line_data, line_vld, line_fas, frame_err, locked}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame A: first bytes from the fixed table, one-cycle latency each
    for (int i = 0; i < 8; i++) begin
      cyc(tv[i].d, 1'b1, tv[i].f, 1'b1);
      check("table data", line_data, tv[i].exp_d);
      check("table vld/fas/err/locked", {line_vld, line_fas, frame_err, locked},
            {1'b1, tv[i].exp_f, 1'b0, 1'b0});
    end
    run_bytes(8, FB - 1, 0, 1'b1);

    // Frame B: correctly spaced FAS locks; payload with random idle gaps
    fas_hdr(1'b1);
    check("locked after 2nd FAS", {locked, frame_err}, 32'h2);
    run_bytes(FASB, FB - 1, 50, 1'b1);

    // Frame C: early FAS at byte 4000
    fas_hdr(1'b1);
    run_bytes(FASB, 3999, 0, 1'b1);
    cyc(8'hF6, 1'b1, 1'b1, 1'b1);
    check("early FAS err", frame_err, 32'h1);
    check("early FAS unlock", locked, 32'h0);
    cyc(8'hF6, 1'b1, 1'b0, 1'b1);
    check("err pulse one cycle", frame_err, 32'h0);
    check("bypass restart passes FAS byte", line_data, 32'hF6);

    // Frame D: restarted at the early FAS, then the expected FAS is missing
    cyc(8'hF6, 1'b1, 1'b0, 1'b1);
    cyc(8'h28, 1'b1, 1'b0, 1'b1);
    cyc(8'h28, 1'b1, 1'b0, 1'b1);
    cyc(8'h28, 1'b1, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    check("restarted keystream byte 6", line_data, 32'hFF);
    run_bytes(FASB + 1, FB - 1, 0, 1'b1);
    cyc(8'h5A, 1'b1, 1'b0, 1'b1);
    check("missing FAS err", {frame_err, locked}, 32'h2);
    check("missing FAS byte passes", line_data, 32'h5A);
    cyc(8'hC3, 1'b1, 1'b0, 1'b1);
    check("unsync pass-through", line_data, 32'hC3);
    run_bytes(0, 49, 0, 1'b1);

    // Frame E: scrambling off, switched on mid-frame, then async reset mid-frame
    fas_hdr(1'b0);
    run_bytes(FASB, 1999, 0, 1'b0);
    run_bytes(2000, 2999, 25, 1'b1);
    @(negedge clk);
    in_vld  = 1'b1;
    in_data = 8'hA5;
    in_fas  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async reset clears outputs", {line_data, line_vld, line_fas, frame_err, locked}, 32'h0);
    @(posedge clk);
    #1;
    check("reset holds outputs", {line_data, line_vld, line_fas, frame_err, locked}, 32'h0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    cyc(8'h3C, 1'b1, 1'b0, 1'b1);
    check("post-reset pass-through", line_data, 32'h3C);
    run_bytes(0, 299, 0, 1'b1);
    fas_hdr(1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b1);
    check("post-reset keystream resumes", line_data, 32'hFF);
    run_bytes(FASB + 1, 200, 30, 1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
